imem_boot_loader: RTL

Instruction-side front end for the single-cycle `mips` core. It accepts a program as a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words in an internal instruction RAM. It holds the core in reset while loading, then releases it and serves `IR` from the RAM, indexed by the core's `pc_out`. It sits directly upstream of `mips`: `instr` drives `IR`, `cpu_rst` drives the core's `rst`, and `pc` is fed from `pc_out`.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_boot_loader_if.sv | 24 ++
 rtl/imem_ram.sv | 26 ++
 rtl/imem_boot_loader.sv | 119 +++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding, the nop word and byte-lane positions.
package imem_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int BYTE_W = 8;

  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready channel carrying the program image.
// master drives data/valid/last, slave returns ready.
interface imem_boot_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_last,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_last,
    output rx_ready
  );

endinterface

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM, no reset.
// Ports: clk, we/waddr/wdata sync write, raddr/rdata async read.
module imem_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a byte stream big-endian into RAM, then serves IR.
// Ports: clk, rst (async low), rx (slave), reload, pc, instr, cpu_rst,
// load_err, words_loaded.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   rx,
  input  logic                reload,
  input  logic [31:0]         pc,
  output logic [31:0]         instr,
  output logic                cpu_rst,
  output logic                load_err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]        r_bcnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W:0]   r_words;
  logic [23:0]       r_shift;

  logic              w_hs;
  logic              w_commit;
  logic              w_full;
  logic              w_clear;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_hit;
  logic              w_unused_pc;

  assign w_full  = (r_waddr == LAST_ADDR);
  assign w_wdata = {r_shift, rx.rx_data};

  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_commit    = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      LOAD: begin
        w_hs     = rx.rx_valid;
        w_commit = w_hs && (r_bcnt == LANE_LAST);
        if (w_hs && rx.rx_last) begin
          w_state_nxt = w_commit ? RUN : ERR;
        end else if (w_commit && w_full) begin
          w_state_nxt = ERR;
        end
      end
      RUN, ERR: begin
        if (reload) begin
          w_state_nxt = LOAD;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD;
      r_bcnt  <= LANE_FIRST;
      r_waddr <= '0;
      r_words <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_bcnt  <= LANE_FIRST;
        r_waddr <= '0;
        r_words <= '0;
      end else if (w_commit) begin
        r_bcnt  <= LANE_FIRST;
        r_waddr <= r_waddr + 1'b1;
        r_words <= r_words + 1'b1;
      end else if (w_hs) begin
        r_bcnt  <= r_bcnt + 1'b1;
        r_shift <= {r_shift[15:0], rx.rx_data};
      end
    end
  end

  imem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_commit),
    .waddr (r_waddr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // Stale RAM words beyond words_loaded read as nop.
  assign w_raddr     = pc[ADDR_W+1:2];
  assign w_hit       = (r_state == RUN)
                    && ({1'b0, w_raddr} < r_words)
                    && (pc[31:ADDR_W+2] == '0);
  assign w_unused_pc = ^pc[1:0];

  assign instr        = w_hit ? w_rdata : NOP_INSTR;
  assign rx.rx_ready  = (r_state == LOAD);
  assign cpu_rst      = (r_state != RUN);
  assign load_err     = (r_state == ERR);
  assign words_loaded = r_words;

endmodule
